// File: rtl/bit_serial_adder_pkg.sv
// Shared types and defaults for the bit-serial adder.
package bit_serial_adder_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } bsa_state_e;

endpackage

// File: rtl/full_adder_cell.sv
// Combinational one-bit full adder, time-multiplexed across the operand by bit_serial_adder.
module full_adder_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ cin_i;
    assign c_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial WIDTH-bit adder, one full-adder bit per clock, LSB first.
// Define BSA_OVF_EN to add the registered signed-overflow output ovf.
module bit_serial_adder
    import bit_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef BSA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CntW = $clog2(WIDTH);

    bsa_state_e       state_q, state_d;
    logic [WIDTH-1:0] shift_a_q, shift_a_d;
    logic [WIDTH-1:0] shift_b_q, shift_b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             fa_s, fa_c;
    logic             last_bit;

    full_adder_cell u_fa (
        .a_i   (shift_a_q[0]),
        .b_i   (shift_b_q[0]),
        .cin_i (carry_q),
        .s_o   (fa_s),
        .c_o   (fa_c)
    );

    assign last_bit = (cnt_q == CntW'(WIDTH - 1));

    always_comb begin
        state_d   = state_q;
        shift_a_d = shift_a_q;
        shift_b_d = shift_b_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    shift_a_d = a;
                    shift_b_d = b;
                    carry_d   = cin;
                    cnt_d     = '0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                shift_a_d = {1'b0, shift_a_q[WIDTH-1:1]};
                shift_b_d = {1'b0, shift_b_q[WIDTH-1:1]};
                // Sum fills from the MSB so bit 0 lands at the LSB after WIDTH shifts.
                sum_d     = {fa_s, sum_q[WIDTH-1:1]};
                carry_d   = fa_c;
                cnt_d     = cnt_q + CntW'(1);
                if (last_bit) begin
                    cout_d  = fa_c;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            shift_a_q <= '0;
            shift_b_q <= '0;
            sum_q     <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            cout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_a_q <= shift_a_d;
            shift_b_q <= shift_b_d;
            sum_q     <= sum_d;
            cnt_q     <= cnt_d;
            carry_q   <= carry_d;
            cout_q    <= cout_d;
        end
    end

`ifdef BSA_OVF_EN
    logic ovf_q, ovf_d;

    // On the last bit carry_q is the carry into the MSB and fa_c the carry out of it.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == StRun && last_bit) begin
            ovf_d = carry_q ^ fa_c;
        end else if (state_q == StDone && out_ready) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed self-checking bench for bit_serial_adder (WIDTH=8); checks ovf when BSA_OVF_EN is set.
module tb_bit_serial_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       busy;
`ifdef BSA_OVF_EN
    logic       ovf;
`endif

    int total = 0;
    int bad   = 0;

    bit_serial_adder #(
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef BSA_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge where out_valid is first seen.
    task automatic run_op(input string tag, input logic [7:0] op_a, input logic [7:0] op_b,
                          input logic op_cin, input logic [7:0] exp_sum, input logic exp_cout,
                          input logic exp_ovf);
        int n;
        a        = op_a;
        b        = op_b;
        cin      = op_cin;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'd8);
        chk({tag, "_sum"}, 32'(sum), 32'(exp_sum));
        chk({tag, "_cout"}, 32'(cout), 32'(exp_cout));
`ifdef BSA_OVF_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("note: %s ovf expectation unknown", tag);
`endif
    endtask

    initial begin
        int vcount;
        logic [7:0] held_sum;
        logic       held_cout;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sum", 32'(sum), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
`ifdef BSA_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("add_3c_0f", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        chk("drain_in_ready", 32'(in_ready), 32'd1);
        chk("drain_out_valid", 32'(out_valid), 32'd0);

        run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        run_op("add_ff_00_c1", 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        @(posedge clk);
        #1;
`ifdef BSA_OVF_EN
        chk("ovf_cleared", 32'(ovf), 32'd0);
`endif
        run_op("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        @(posedge clk);
        #1;

        // Backpressure: result must hold while out_ready is low.
        out_ready = 1'b0;
        run_op("bp", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0);
        held_sum  = 8'h00;
        held_cout = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_sum", 32'(sum), 32'(held_sum));
            chk("bp_cout", 32'(cout), 32'(held_cout));
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;

        // in_valid during RUN must be ignored.
        a        = 8'h22;
        b        = 8'h33;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        a        = 8'h11;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("ign_in_ready", 32'(in_ready), 32'd0);
        vcount = 2;
        while (out_valid !== 1'b1 && vcount < 40) begin
            @(posedge clk);
            #1;
            vcount++;
        end
        chk("ign_latency", 32'(vcount), 32'd8);
        chk("ign_sum", 32'(sum), 32'h55);
        chk("ign_cout", 32'(cout), 32'd0);
        vcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) vcount++;
        end
        chk("ign_no_second_valid", 32'(vcount), 32'd0);
        chk("ign_idle_after", 32'(in_ready), 32'd1);

        // Asynchronous reset in the middle of RUN.
        a        = 8'h3C;
        b        = 8'h0F;
        cin      = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_sum", 32'(sum), 32'd0);
        chk("arst_cout", 32'(cout), 32'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("post_rst", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bit_serial_adder.md
# bit_serial_adder

Bit-serial N-bit adder: accepts two operands and a carry-in through a valid/ready handshake. It computes one full-adder bit per clock, LSB first. It returns the sum and carry-out through a second valid/ready handshake. It is the area-minimal addition datapath alongside the team's subtractor primitives, and is used where a single one-bit full-adder cell can be time-multiplexed across an operand.

## Interface
- WIDTH, 8, operand/sum width in bits (≥ 2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands a, b, cin valid
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  operand A, unsigned or two's complement
- b  input  WIDTH  operand B
- cin  input  1  carry-in
- out_valid  output  1  sum/cout valid (high only in DONE)
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  result a + b + cin, mod 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1
- busy  output  1  high in RUN or DONE
- ovf  output  1  signed overflow (present only with BSA_OVF_EN)

## Operation
- One clock, clk.
- Reset is asynchronous and active-low on rst_n.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch a→shift_a, b→shift_b, cin→carry; clear bit counter to 0; go to RUN.
- RUN, each cycle:
  - s = shift_a[0]^shift_b[0]^carry; c = majority(shift_a[0], shift_b[0], carry).
  - shift_a and shift_b shift right by 1; s shifts into sum MSB, sum register shifts right; carry←c; counter+1.
  - When counter reaches WIDTH-1 (last bit): go to DONE, and cout←c.
- DONE:
  - out_valid=1; sum and cout held stable.
  - On out_ready: go to IDLE.
  - out_valid stays high indefinitely while out_ready=0.
- in_valid outside IDLE is ignored; operands are not queued.
- No back-to-back overlap. Issue interval is WIDTH+2 cycles minimum: accept edge, WIDTH run edges, one drain edge.
- Arithmetic:
  - sum = (a+b+cin)[WIDTH-1:0]; cout = bit WIDTH of the full sum.
  - Counter width $clog2(WIDTH).
- sum/cout are undefined-but-deterministic partial values during RUN. Consumers sample only when out_valid=1.
- Reset mid-operation: the operation is aborted, and the block returns to IDLE immediately and asynchronously.

## Timing
- Reset values:
  - State: IDLE.
  - Outputs: in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0.
  - Internal: shift_a, shift_b, carry and counter are all 0.
- Latency: if operands are accepted on edge k, out_valid rises after edge k+WIDTH. Result visible WIDTH cycles after acceptance.
- Result transfer occurs on the edge where out_valid&out_ready. in_ready rises after that edge.
- in_ready, out_valid and busy are registered-state decodes; they have no combinational path from inputs.
- rst_n deassertion is synchronized externally; the block only requires an asynchronous assert.

## Configuration
- BSA_OVF_EN defined:
  - The ovf port exists.
  - ovf = carry into MSB XOR carry out of MSB, registered on the last RUN cycle.
  - ovf is held through DONE and cleared to 0 on leaving DONE.
- BSA_OVF_EN undefined: the ovf port and its logic are absent; all other behaviour is identical.

## Structure
- Package bit_serial_adder_pkg contains:
  - The FSM state typedef (IDLE, RUN, DONE).
  - The default WIDTH constant.
- Sub-module full_adder_cell: combinational 1-bit (a, b, cin) → (s, c), instantiated once in the RUN datapath.

## Test plan
- WIDTH=8, a=0x3C, b=0x0F, cin=0, out_ready=1 → out_valid after 8 cycles; sum=0x4B, cout=0, ovf=0.
- a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Also a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1.
- a=0x7F, b=0x01, cin=0 with BSA_OVF_EN → sum=0x80, cout=0, ovf=1. Build without the macro → no ovf port, same sum.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid, sum and cout stable; in_ready=0. After out_ready pulse → in_ready=1 next cycle.
- in_valid pulsed with a=0x11 during RUN of a=0x22, b=0x33 → ignored; result 0x55; no second out_valid.
- Assert rst_n low at RUN cycle 4 → state IDLE immediately; outputs reach reset values. A new operation a=0x01, b=0x02 → sum=0x03 after 8 cycles.
